vga_fb_arbiter: RTL and testbench

Time-slot arbiter and scan-out sequencer for the single-port 160x144x12-bit Game Gear framebuffer RAM. Shares the RAM between VGA scan-out reads and VDP pixel writes, and maps the 640x480 VGA raster onto the framebuffer with 3x integer scaling, centred with a border colour. Sits between the VDP pixel writer, the framebuffer RAM and the VGA DAC, and runs beside the VGA timing generator in the clk_50 domain.

---
 rtl/vga_fb_arbiter_pkg.sv | 25 ++
 rtl/vga_fb_arbiter_fifo.sv | 51 +++++
 rtl/vga_fb_arbiter.sv | 129 ++++++++++++
 tb/tb_vga_fb_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_fb_arbiter_pkg.sv
// Shared constants and types for the framebuffer arbiter: window geometry,
// framebuffer size and the queued write entry layout.
package vga_fb_arbiter_pkg;

  localparam logic [9:0]  WIN_X0     = 10'd80;
  localparam logic [9:0]  WIN_X1     = 10'd560;
  localparam logic [9:0]  WIN_Y0     = 10'd24;
  localparam logic [9:0]  WIN_Y1     = 10'd456;
  localparam logic [9:0]  X_LAST     = 10'd639;
  localparam logic [14:0] FB_W       = 15'd160;
  localparam logic [14:0] FB_SIZE    = 15'd23040;
  localparam logic [1:0]  SCALE_LAST = 2'd2;
  localparam logic [2:0]  FIFO_DEPTH = 3'd4;
  localparam int          ENTRY_W    = 27;

  typedef struct packed {
    logic [14:0] addr;
    logic [11:0] data;
  } wr_entry_t;

  function automatic logic in_span(logic [9:0] v, logic [9:0] lo, logic [9:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_fb_arbiter_fifo.sv
// fb_write_fifo: 4-deep synchronous FIFO holding queued {addr,data} pixel
// writes; head is presented combinationally on dout.
module fb_write_fifo
  import vga_fb_arbiter_pkg::*;
(
  input  logic                 clk_50,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic [ENTRY_W-1:0]   din,
  output logic [ENTRY_W-1:0]   dout,
  output logic                 full,
  output logic                 empty,
  output logic [2:0]           level
);

  logic [ENTRY_W-1:0] store [0:3];
  logic [1:0]         wr_ptr;
  logic [1:0]         rd_ptr;
  logic [2:0]         count;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == FIFO_DEPTH);
  assign empty   = (count == 3'd0);
  assign level   = count;
  assign dout    = store[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk_50) begin
    if (do_push) store[wr_ptr] <= din;
  end

  always_ff @(posedge clk_50) begin
    if (rst) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 2'd1;
      if (do_pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Framebuffer time-slot arbiter: vga_ph=0 cycles read for scan-out (3x scaled,
// centred), vga_ph=1 cycles drain one queued VDP write.
module vga_fb_arbiter
  import vga_fb_arbiter_pkg::*;
#(
  parameter logic [11:0] BORDER_RGB = 12'h000
) (
  input  logic        clk_50,
  input  logic        rst,
  input  logic        vga_ph,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic        pix_de,
  // Write port: an entry is taken on an edge where wr_valid && wr_ready; the
  // writer holds wr_addr/wr_data until then. wr_ready never depends on wr_valid.
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [14:0] wr_addr,
  input  logic [11:0] wr_data,
  output logic [14:0] mem_addr,
  output logic        mem_we,
  output logic [11:0] mem_wdata,
  input  logic [11:0] mem_rdata,
  output logic [11:0] rgb_out,
  output logic [2:0]  fifo_level
);

  logic [7:0]         src_x;
  logic [1:0]         sub_x;
  logic [1:0]         sub_y;
  logic [14:0]        row_base;
  logic [7:0]         cur_src_x;
  logic [1:0]         cur_sub_x;
  logic [14:0]        rd_addr;
  logic               row_in;
  logic               in_win;
  logic               prev_win;
  logic               prev_de;
  logic               push;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] head;
  wr_entry_t          head_e;
  logic [2:0]         level_next;

  assign push   = wr_valid && wr_ready && !fifo_full;
  assign pop    = vga_ph && !fifo_empty;
  assign head_e = head;

  fb_write_fifo u_fifo (
    .clk_50 (clk_50),
    .rst    (rst),
    .push   (push),
    .pop    (pop),
    .din    ({wr_addr, wr_data}),
    .dout   (head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (fifo_level)
  );

  always_comb begin
    row_in    = in_span(pix_y, WIN_Y0, WIN_Y1);
    in_win    = pix_de && row_in && in_span(pix_x, WIN_X0, WIN_X1);
    // The first window column restarts the horizontal walk in the same cycle.
    cur_src_x = (pix_x == WIN_X0) ? 8'd0 : src_x;
    cur_sub_x = (pix_x == WIN_X0) ? 2'd0 : sub_x;
    rd_addr   = row_base + {7'd0, cur_src_x};
    level_next = fifo_level;
    if (push && !pop)      level_next = fifo_level + 3'd1;
    else if (!push && pop) level_next = fifo_level - 3'd1;
  end

  always_ff @(posedge clk_50) begin
    if (rst) wr_ready <= 1'b0;
    else     wr_ready <= (level_next != FIFO_DEPTH);
  end

  always_ff @(posedge clk_50) begin
    if (rst) begin
      src_x     <= 8'd0;
      sub_x     <= 2'd0;
      sub_y     <= 2'd0;
      row_base  <= 15'd0;
      prev_win  <= 1'b0;
      prev_de   <= 1'b0;
      mem_addr  <= 15'd0;
      mem_we    <= 1'b0;
      mem_wdata <= 12'd0;
      rgb_out   <= 12'd0;
    end else if (!vga_ph) begin
      mem_addr <= rd_addr;
      mem_we   <= 1'b0;
      // mem_rdata now carries the read issued in the previous read slot.
      rgb_out  <= prev_win ? mem_rdata : (prev_de ? BORDER_RGB : 12'h000);
      prev_win <= in_win;
      prev_de  <= pix_de;
      if (in_win) begin
        if (cur_sub_x == SCALE_LAST) begin
          sub_x <= 2'd0;
          src_x <= cur_src_x + 8'd1;
        end else begin
          sub_x <= cur_sub_x + 2'd1;
          src_x <= cur_src_x;
        end
      end
      if (pix_de && pix_y == WIN_Y0 && pix_x == 10'd0) begin
        row_base <= 15'd0;
        sub_y    <= 2'd0;
      end else if (pix_de && row_in && pix_x == X_LAST) begin
        if (sub_y == SCALE_LAST) begin
          sub_y    <= 2'd0;
          row_base <= row_base + FB_W;
        end else begin
          sub_y <= sub_y + 2'd1;
        end
      end
    end else begin
      // Out-of-range entries are still popped, just never strobed into the RAM.
      mem_we <= pop && (head_e.addr < FB_SIZE);
      if (pop) begin
        mem_addr  <= head_e.addr;
        mem_wdata <= head_e.data;
      end
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter: reset, scaled scan-out against a mapping
// model, FIFO fill/back-pressure, out-of-range discard and slot discipline.
module tb_vga_fb_arbiter;

  localparam logic [11:0] BORDER = 12'hF0F;

  logic        clk_50;
  logic        rst;
  logic        vga_ph;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic        pix_de;
  logic        wr_valid;
  logic        wr_ready;
  logic [14:0] wr_addr;
  logic [11:0] wr_data;
  logic [14:0] mem_addr;
  logic        mem_we;
  logic [11:0] mem_wdata;
  logic [11:0] mem_rdata;
  logic [11:0] rgb_out;
  logic [2:0]  fifo_level;

  vga_fb_arbiter #(.BORDER_RGB(BORDER)) dut (
    .clk_50     (clk_50),
    .rst        (rst),
    .vga_ph     (vga_ph),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_de     (pix_de),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .rgb_out    (rgb_out),
    .fifo_level (fifo_level)
  );

  // ---------------- clock / reset ----------------
  initial clk_50 = 1'b0;
  always #10 clk_50 = ~clk_50;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- RAM model (preloaded with value = address) ----------------
  logic [11:0] ram [0:32767];
  initial begin
    for (int a = 0; a < 32768; a++) ram[a] <= 12'(a);
  end
  always @(posedge clk_50) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  int          we_count = 0;
  logic [26:0] exp_q[$];
  logic [26:0] exp_w;
  logic        ph_at_edge = 1'b0;
  logic        ph_run;
  logic        have_prev;
  logic [11:0] prev_exp;
  string       prev_tag;
  logic [26:0] wr_vec [0:7];
  int          w_idx;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk_50) ph_at_edge <= vga_ph;

  always @(negedge clk_50) begin
    if (!rst && mem_we) begin
      we_count++;
      check("we_slot", {31'd0, ph_at_edge}, 32'd1);
      if (exp_q.size() == 0) check("we_unexpected", {31'd0, mem_we}, 32'd0);
      else begin
        exp_w = exp_q.pop_front();
        check("we_entry", {5'd0, mem_addr, mem_wdata}, {5'd0, exp_w});
      end
    end
  end

  // ---------------- reference mapping ----------------
  function automatic logic in_win(int x, int y, logic de);
    return de && x >= 80 && x < 560 && y >= 24 && y < 456;
  endfunction

  function automatic int fb_addr(int x, int y);
    return ((y - 24) / 3) * 160 + (x - 80) / 3;
  endfunction

  function automatic logic [11:0] exp_rgb(int x, int y, logic de);
    int a;
    if (!de) return 12'h000;
    if (!in_win(x, y, de)) return BORDER;
    a = fb_addr(x, y);
    return a[11:0];
  endfunction

  function automatic logic [26:0] stream_entry(int k);
    int a;
    a = 160 * (10 + k / 50) + 100 + (k % 50);
    return {15'(a), 12'(k * 13 + 7)};
  endfunction

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk_50);
    #1;
    if (ph_run) vga_ph = ~vga_ph;
  endtask

  task automatic send_until(input int n);
    int   budget;
    logic rdy;
    budget = 0;
    while (w_idx < n && budget < 200) begin
      wr_valid = 1'b1;
      {wr_addr, wr_data} = wr_vec[w_idx];
      rdy = wr_ready;
      step();
      if (rdy) w_idx++;
      budget++;
    end
    wr_valid = 1'b0;
    check("send_done", w_idx, n);
  endtask

  task automatic drive_pixel(input int x, input int y, input logic de);
    logic [11:0] held;
    vga_ph = 1'b0;
    pix_x  = 10'(x);
    pix_y  = 10'(y);
    pix_de = de;
    step();
    if (have_prev) check(prev_tag, {20'd0, rgb_out}, {20'd0, prev_exp});
    check("rd_we", {31'd0, mem_we}, 32'd0);
    if (in_win(x, y, de)) check("rd_addr", {17'd0, mem_addr}, fb_addr(x, y));
    held     = prev_exp;
    prev_exp = exp_rgb(x, y, de);
    prev_tag = $sformatf("rgb(%0d,%0d)", x, y);
    vga_ph = 1'b1;
    step();
    if (have_prev) check("rgb_hold", {20'd0, rgb_out}, {20'd0, held});
    have_prev = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    int xs [0:7];
    rst = 1'b1; vga_ph = 1'b0; pix_x = '0; pix_y = '0; pix_de = 1'b0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    ph_run = 1'b1; have_prev = 1'b0; prev_exp = '0; prev_tag = "";
    w_idx = 0;
    xs[0] = 0; xs[1] = 79; xs[2] = 80; xs[3] = 81;
    xs[4] = 82; xs[5] = 83; xs[6] = 84; xs[7] = 639;

    // reset state
    repeat (3) step();
    check("rst_ready", {31'd0, wr_ready}, 32'd0);
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_addr", {17'd0, mem_addr}, 32'd0);
    check("rst_wdata", {20'd0, mem_wdata}, 32'd0);
    check("rst_rgb", {20'd0, rgb_out}, 32'd0);
    check("rst_level", {29'd0, fifo_level}, 32'd0);
    rst = 1'b0;
    step();
    check("ready_after_rst", {31'd0, wr_ready}, 32'd1);

    // two queued writes dropped by a mid-line reset
    ph_run = 1'b0; vga_ph = 1'b0;
    wr_vec[0] = {15'd300, 12'h111};
    wr_vec[1] = {15'd301, 12'h222};
    w_idx = 0;
    send_until(2);
    check("level_queued", {29'd0, fifo_level}, 32'd2);
    pix_de = 1'b1; pix_x = 10'd300; pix_y = 10'd100;
    ph_run = 1'b1; rst = 1'b1;
    step();
    check("ready_in_rst", {31'd0, wr_ready}, 32'd0);
    step(); step();
    rst = 1'b0;
    step();
    check("ready_release", {31'd0, wr_ready}, 32'd1);
    check("level_release", {29'd0, fifo_level}, 32'd0);
    check("rgb_release", {20'd0, rgb_out}, 32'd0);
    base = we_count;
    repeat (12) step();
    check("no_we_after_rst", we_count - base, 0);
    pix_de = 1'b0;

    // scan-out with a concurrent write stream into unscanned framebuffer cells
    ph_run = 1'b0;
    for (int k = 0; k < 200; k++) exp_q.push_back(stream_entry(k));
    base = we_count;
    fork
      begin
        for (int y = 22; y <= 457; y++) begin
          if (y == 24 || y == 455) begin
            for (int x = 0; x < 640; x++) drive_pixel(x, y, 1'b1);
          end else begin
            for (int i = 0; i < 8; i++) drive_pixel(xs[i], y, 1'b1);
          end
          drive_pixel(700, y, 1'b0);
        end
        drive_pixel(700, 458, 1'b0);
      end
      begin
        int   k;
        int   budget;
        logic rdy;
        k = 0; budget = 0;
        while (k < 200 && budget < 3000) begin
          wr_valid = 1'b1;
          {wr_addr, wr_data} = stream_entry(k);
          rdy = wr_ready;
          step();
          if (rdy) k++;
          budget++;
        end
        wr_valid = 1'b0;
        check("stream_done", k, 200);
      end
    join
    ph_run = 1'b1;
    repeat (4) step();
    check("stream_we_count", we_count - base, 200);
    check("stream_q_empty", exp_q.size(), 0);

    // six back-to-back writes: fill with read slots only, then push-while-full + pop
    ph_run = 1'b0; vga_ph = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wr_vec[i] = {15'(8120 + i), 12'(12'hA00 + i)};
      exp_q.push_back(wr_vec[i]);
    end
    base = we_count;
    w_idx = 0;
    send_until(4);
    check("ready_full", {31'd0, wr_ready}, 32'd0);
    check("level_full", {29'd0, fifo_level}, 32'd4);
    wr_valid = 1'b1;
    {wr_addr, wr_data} = wr_vec[4];
    vga_ph = 1'b1;
    step();
    check("level_push_pop", {29'd0, fifo_level}, 32'd3);
    vga_ph = 1'b0;
    ph_run = 1'b1;
    send_until(6);
    repeat (20) step();
    check("burst_we_count", we_count - base, 6);
    check("burst_q_empty", exp_q.size(), 0);
    check("burst_level", {29'd0, fifo_level}, 32'd0);

    // out-of-range entry discarded, following entry intact
    wr_vec[0] = {15'd23040, 12'hBAD};
    wr_vec[1] = {15'd5, 12'h5A5};
    exp_q.push_back(wr_vec[1]);
    base = we_count;
    w_idx = 0;
    send_until(2);
    repeat (10) step();
    check("discard_we_count", we_count - base, 1);
    check("discard_q_empty", exp_q.size(), 0);
    check("ram_addr5", {20'd0, ram[5]}, 32'h5A5);
    check("ram_addr23040", {20'd0, ram[23040]}, 32'hA00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
